// File: rtl/instr_fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : instr_fetch_unit                                              |
// | Purpose  : Fetch front end. Holds the program counter, issues one ROM     |
// |            byte address per cycle, tracks the 1-cycle ROM read latency   |
// |            and buffers returned words in a 2-entry FIFO so decode        |
// |            backpressure never drops an instruction. Branch/jump          |
// |            redirects flush every wrong-path fetch.                        |
// | Ports    : CLK, RST_N (async active-low)                                 |
// |            ROM_ADDR  (out 32) current fetch_pc, combinational            |
// |            ROM_DATA  (in  32) word for the address issued last cycle     |
// |            REDIRECT, REDIRECT_PC (in) new fetch target, bits [1:0] drop   |
// |            READY_IN  (in)     decode accepts the FIFO head               |
// |            VALID_OUT, INSTR_OUT, PC_OUT (out) registered FIFO head        |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,  // low 2 bits must be 0
  parameter int          FIFO_DEPTH = 2               // only 2 is supported
) (
  input  logic        CLK,
  input  logic        RST_N,
  output logic [31:0] ROM_ADDR,
  input  logic [31:0] ROM_DATA,
  input  logic        REDIRECT,
  input  logic [31:0] REDIRECT_PC,
  input  logic        READY_IN,
  output logic        VALID_OUT,
  output logic [31:0] INSTR_OUT,
  output logic [31:0] PC_OUT
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [31:0]      fetch_pc_q,   fetch_pc_d;
  logic             pending_q,    pending_d;
  logic [31:0]      pending_pc_q, pending_pc_d;
  logic [CNT_W-1:0] count_q,      count_d;
  // Entry 0 is the head and drives the outputs directly; entry 1 is behind it.
  logic [31:0]      head_instr_q, head_instr_d;
  logic [31:0]      head_pc_q,    head_pc_d;
  logic [31:0]      tail_instr_q, tail_instr_d;
  logic [31:0]      tail_pc_q,    tail_pc_d;

  logic             pop;
  logic             push;
  logic             issue;
  logic [CNT_W:0]   occ_after_pop;

  // The ROM ignores the byte offset, and so do we.
  logic             unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^REDIRECT_PC[1:0];

  assign ROM_ADDR  = fetch_pc_q;
  assign VALID_OUT = (count_q != '0);
  assign INSTR_OUT = head_instr_q;
  assign PC_OUT    = head_pc_q;

  always_comb begin
    pop  = VALID_OUT & READY_IN;
    push = pending_q & ~REDIRECT;
    // Entries already committed (stored + in flight) once this cycle's pop
    // leaves; issuing only while this is <= 1 guarantees room on return.
    occ_after_pop = {1'b0, count_q} + (CNT_W + 1)'(pending_q) - (CNT_W + 1)'(pop);
    issue = ~REDIRECT & (occ_after_pop <= (CNT_W + 1)'(1));

    fetch_pc_d   = fetch_pc_q;
    pending_d    = pending_q;
    pending_pc_d = pending_pc_q;
    count_d      = count_q;
    head_instr_d = head_instr_q;
    head_pc_d    = head_pc_q;
    tail_instr_d = tail_instr_q;
    tail_pc_d    = tail_pc_q;

    if (REDIRECT) begin
      // A pop in this cycle already belongs to decode; everything else is
      // wrong-path, including the word arriving on ROM_DATA right now.
      count_d    = '0;
      pending_d  = 1'b0;
      fetch_pc_d = {REDIRECT_PC[31:2], 2'b00};
    end else begin
      if (issue) begin
        pending_d    = 1'b1;
        pending_pc_d = fetch_pc_q;
        fetch_pc_d   = fetch_pc_q + 32'd4;
      end else begin
        pending_d = 1'b0;
      end

      case ({push, pop})
        2'b10: begin
          if (count_q == '0) begin
            head_instr_d = ROM_DATA;
            head_pc_d    = pending_pc_q;
          end else begin
            tail_instr_d = ROM_DATA;
            tail_pc_d    = pending_pc_q;
          end
          count_d = count_q + CNT_W'(1);
        end
        2'b01: begin
          head_instr_d = tail_instr_q;
          head_pc_d    = tail_pc_q;
          count_d      = count_q - CNT_W'(1);
        end
        2'b11: begin
          // Occupancy unchanged; new word lands behind whatever remains.
          if (count_q == CNT_W'(1)) begin
            head_instr_d = ROM_DATA;
            head_pc_d    = pending_pc_q;
          end else begin
            head_instr_d = tail_instr_q;
            head_pc_d    = tail_pc_q;
            tail_instr_d = ROM_DATA;
            tail_pc_d    = pending_pc_q;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      fetch_pc_q   <= RESET_PC;
      pending_q    <= 1'b0;
      pending_pc_q <= 32'h0;
      count_q      <= '0;
      head_instr_q <= 32'h0;
      head_pc_q    <= 32'h0;
      tail_instr_q <= 32'h0;
      tail_pc_q    <= 32'h0;
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      pending_q    <= pending_d;
      pending_pc_q <= pending_pc_d;
      count_q      <= count_d;
      head_instr_q <= head_instr_d;
      head_pc_q    <= head_pc_d;
      tail_instr_q <= tail_instr_d;
      tail_pc_q    <= tail_pc_d;
    end
  end

  always @(posedge CLK) begin
    if (RST_N) begin
      assert (({1'b0, count_q} + (CNT_W + 1)'(pending_q)) <= (CNT_W + 1)'(FIFO_DEPTH));
      assert (!(push && !pop && (count_q == CNT_W'(FIFO_DEPTH))));
      assert (!(pop && (count_q == '0)));
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_instr_fetch_unit                                           |
// | Purpose  : Directed and randomised self-checking bench for              |
// |            instr_fetch_unit with a 1-cycle registered ROM model.         |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_instr_fetch_unit;

  logic        CLK;
  logic        RST_N;
  logic [31:0] ROM_ADDR;
  logic [31:0] ROM_DATA;
  logic        REDIRECT;
  logic [31:0] REDIRECT_PC;
  logic        READY_IN;
  logic        VALID_OUT;
  logic [31:0] INSTR_OUT;
  logic [31:0] PC_OUT;

  int tests_run    = 0;
  int tests_failed = 0;

  instr_fetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (2)
  ) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .ROM_ADDR    (ROM_ADDR),
    .ROM_DATA    (ROM_DATA),
    .REDIRECT    (REDIRECT),
    .REDIRECT_PC (REDIRECT_PC),
    .READY_IN    (READY_IN),
    .VALID_OUT   (VALID_OUT),
    .INSTR_OUT   (INSTR_OUT),
    .PC_OUT      (PC_OUT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return 32'hC0DE_0000 | {16'h0000, a[15:0]};
  endfunction

  always @(posedge CLK) ROM_DATA <= rom_word(ROM_ADDR);

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_head(input string tag, input logic [31:0] pc);
    chk({tag, "_valid"}, {31'h0, VALID_OUT}, 32'd1);
    chk({tag, "_pc"},    PC_OUT,             pc);
    chk({tag, "_instr"}, INSTR_OUT,          rom_word(pc));
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid0"}, {31'h0, VALID_OUT}, 32'd0);
  endtask

  logic [31:0] exp_pc;
  logic [31:0] held_pc;
  logic [31:0] held_instr;
  logic [31:0] rpc;
  logic        prev_hold;
  logic        rdy;
  logic        rdr;
  int          since_redir;

  initial begin
    RST_N       = 1'b0;
    READY_IN    = 1'b0;
    REDIRECT    = 1'b0;
    REDIRECT_PC = 32'h0;

    // Reset state, before any clock edge
    #3;
    chk("rst_valid", {31'h0, VALID_OUT}, 32'd0);
    chk("rst_instr", INSTR_OUT, 32'h0);
    chk("rst_pc",    PC_OUT,    32'h0);
    chk("rst_addr",  ROM_ADDR,  32'h0);
    tick();
    tick();

    // 1: release, stream with READY_IN high
    RST_N    = 1'b1;
    READY_IN = 1'b1;
    tick();
    chk_idle("fill1");
    chk("fill1_addr", ROM_ADDR, 32'h4);
    tick();
    chk_head("s0", 32'h0);
    for (int n = 1; n < 4; n++) begin
      tick();
      chk_head("stream", 32'(n * 4));
    end
    tick();
    chk_head("s10", 32'h10);

    // 2: backpressure with 0x10 at the head
    READY_IN = 1'b0;
    for (int n = 0; n < 5; n++) begin
      tick();
      chk_head("stall", 32'h10);
      chk("stall_addr", ROM_ADDR, 32'h18);
    end
    READY_IN = 1'b1;
    tick();
    chk_head("rel14", 32'h14);
    tick();
    chk_head("rel18", 32'h18);
    tick();
    chk_head("rel1c", 32'h1C);

    // 3: redirect with the FIFO full
    READY_IN = 1'b0;
    tick();
    chk_head("full1c", 32'h1C);
    REDIRECT    = 1'b1;
    REDIRECT_PC = 32'h200;
    tick();
    chk_idle("rd200_a");
    chk("rd200_addr", ROM_ADDR, 32'h200);
    REDIRECT = 1'b0;
    READY_IN = 1'b1;
    tick();
    chk_idle("rd200_b");
    tick();
    chk_head("rd200", 32'h200);

    // 4: unaligned target while streaming (pop of 0x200 honoured)
    REDIRECT    = 1'b1;
    REDIRECT_PC = 32'h203;
    tick();
    chk_idle("rd203_a");
    chk("rd203_addr", ROM_ADDR, 32'h200);
    REDIRECT = 1'b0;
    tick();
    chk_idle("rd203_b");
    tick();
    chk_head("rd203", 32'h200);

    // 5: wrap from the last word of the address space
    REDIRECT    = 1'b1;
    REDIRECT_PC = 32'hFFFF_FFFC;
    tick();
    chk_idle("wrap_a");
    REDIRECT = 1'b0;
    tick();
    tick();
    chk_head("wrap_top", 32'hFFFF_FFFC);
    tick();
    chk_head("wrap_zero", 32'h0);
    tick();
    chk_head("wrap_four", 32'h4);

    // Back-to-back redirects: last one wins
    REDIRECT    = 1'b1;
    REDIRECT_PC = 32'h300;
    tick();
    chk_idle("b2b_a");
    REDIRECT_PC = 32'h400;
    tick();
    chk_idle("b2b_b");
    chk("b2b_addr", ROM_ADDR, 32'h400);
    REDIRECT = 1'b0;
    tick();
    chk_idle("b2b_c");
    tick();
    chk_head("b2b", 32'h400);
    tick();
    chk_head("b2b_next", 32'h404);

    // 6: asynchronous reset between edges
    RST_N = 1'b0;
    #2;
    chk("arst_valid", {31'h0, VALID_OUT}, 32'd0);
    chk("arst_pc",    PC_OUT,   32'h0);
    chk("arst_instr", INSTR_OUT, 32'h0);
    chk("arst_addr",  ROM_ADDR, 32'h0);
    #2;
    RST_N = 1'b1;
    tick();
    chk_idle("arst_fill");
    tick();
    chk_head("arst_first", 32'h0);

    // Random READY_IN / REDIRECT against an ordering/latency reference
    exp_pc      = 32'h0;
    held_pc     = 32'h0;
    held_instr  = 32'h0;
    prev_hold   = 1'b0;
    since_redir = 100;
    for (int i = 0; i < 400; i++) begin
      if (i == 0) begin
        rdy = 1'b0;
        rdr = 1'b1;
        rpc = 32'h0000_1000;
      end else begin
        rdy = ($urandom_range(0, 3) != 0);
        rdr = ($urandom_range(0, 15) == 0);
        rpc = $urandom;
      end
      READY_IN    = rdy;
      REDIRECT    = rdr;
      REDIRECT_PC = rpc;

      if (VALID_OUT && rdy) begin
        chk("rnd_pop_pc",    PC_OUT,    exp_pc);
        chk("rnd_pop_instr", INSTR_OUT, rom_word(exp_pc));
        exp_pc = exp_pc + 32'd4;
      end
      if (rdr) begin
        exp_pc      = {rpc[31:2], 2'b00};
        since_redir = 0;
      end
      prev_hold  = VALID_OUT & ~rdy & ~rdr;
      held_pc    = PC_OUT;
      held_instr = INSTR_OUT;

      tick();

      since_redir++;
      if (since_redir <= 2)
        chk_idle("rnd_flush");
      if (prev_hold) begin
        chk("rnd_hold_valid", {31'h0, VALID_OUT}, 32'd1);
        chk("rnd_hold_pc",    PC_OUT,    held_pc);
        chk("rnd_hold_instr", INSTR_OUT, held_instr);
      end
    end

    REDIRECT = 1'b0;
    READY_IN = 1'b1;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
